// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm -- multicycle control unit for the ARM-subset processor.
//
// Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// states and drives the datapath selects combinationally from the current
// state and the latched instruction fields (Moore outputs, no extra latency).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   Op, Funct, Rd       Instr[27:26], Instr[25:20], Instr[15:12]
//   IRWrite, NextPC     unconditional strobes (fetch)
//   AdrSrc, ALUSrcA     memory address select, ALU A select
//   ALUSrcB, ResultSrc  ALU B select, result select
//   ALUControl          00 ADD, 01 SUB, 10 AND, 11 ORR
//   ImmSrc, RegSrc      decoded from Op in every state
//   FlagW, PCS, RegW,   conditional-write requests, gated downstream
//   MemW                by CondEx
// ---------------------------------------------------------------------------
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t state_reg;
    state_t state_next;
    state_t out_state;   // state used for output decode (FETCH while in reset)
    logic   alu_op;
    logic   branch;
    logic   alu_known;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (Op)
                    2'b01:   state_next = MEMADR;
                    2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;   // illegal Op: abandon quietly
                endcase
            end
            MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            default:  state_next = FETCH;          // MEMWB, MEMWR, ALUWB, BRANCH
        endcase
    end

    // Moore outputs plus ALU decode
    always_comb begin
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        FlagW      = 2'b00;
        RegW       = 1'b0;
        MemW       = 1'b0;
        alu_op     = 1'b0;
        branch     = 1'b0;
        alu_known  = 1'b0;

        // During reset the selects show their FETCH values; the fetch
        // strobes are masked further down.
        out_state = reset ? FETCH : state_reg;

        case (out_state)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMRD:    AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            ALUWB:    RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase

        if (alu_op) begin
            case (Funct[4:1])
                4'b0100: begin ALUControl = 2'b00; alu_known = 1'b1; end
                4'b0010: begin ALUControl = 2'b01; alu_known = 1'b1; end
                4'b0000: begin ALUControl = 2'b10; alu_known = 1'b1; end
                4'b1100: begin ALUControl = 2'b11; alu_known = 1'b1; end
                default: begin ALUControl = 2'b00; alu_known = 1'b0; end
            endcase
            // Unrecognised opcodes never touch the flags.
            if (alu_known) begin
                FlagW[1] = Funct[0];
                FlagW[0] = Funct[0] & ~ALUControl[1];   // ADD or SUB
            end
        end

        if (reset) begin
            IRWrite = 1'b0;
            NextPC  = 1'b0;
        end
    end

    assign PCS    = (RegW & (Rd == 4'hF)) | branch;
    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm -- self-checking bench for mc_ctrl_fsm.
// Each instruction is expanded into its list of control steps from the
// instruction class; every cycle the whole control word is compared with the
// word the reference model derives for that step.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW;
    logic       PCS, RegW, MemW;

    int checks = 0;
    int errors = 0;

    // Step kinds of the reference model
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                   S_MEMWB = 4, S_MEMWR = 5, S_EXR = 6, S_EXI = 7,
                   S_ALUWB = 8, S_BRANCH = 9;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .FlagW(FlagW), .PCS(PCS),
        .RegW(RegW), .MemW(MemW)
    );

    always #5 clk = ~clk;

    // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,ImmSrc,RegSrc,FlagW,PCS,RegW,MemW}
    function automatic logic [18:0] observed();
        return {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                ImmSrc, RegSrc, FlagW, PCS, RegW, MemW};
    endfunction

    function automatic logic [18:0] model(int k, logic [1:0] op, logic [5:0] f,
                                          logic [3:0] rd, bit rst);
        logic irw = 0, npc = 0, adr = 0, asa = 0, pcs = 0, rw = 0, mw = 0;
        logic [1:0] asb = 0, rs = 0, ac = 0, fw = 0;
        int kk = rst ? S_FETCH : k;
        if (kk == S_FETCH)  begin irw = 1; npc = 1; asa = 1; asb = 2; rs = 2; end
        if (kk == S_DECODE) begin asa = 1; asb = 2; rs = 2; end
        if (kk == S_MEMADR) asb = 1;
        if (kk == S_MEMRD)  adr = 1;
        if (kk == S_MEMWB)  begin rs = 1; rw = 1; end
        if (kk == S_MEMWR)  begin adr = 1; mw = 1; end
        if (kk == S_EXI || kk == S_BRANCH) asb = 1;
        if (kk == S_BRANCH) rs = 2;
        if (kk == S_ALUWB)  rw = 1;
        if (kk == S_EXR || kk == S_EXI) begin
            bit ok = 1;
            if      (f[4:1] == 4'd4)  ac = 0;   // ADD
            else if (f[4:1] == 4'd2)  ac = 1;   // SUB
            else if (f[4:1] == 4'd0)  ac = 2;   // AND
            else if (f[4:1] == 4'd12) ac = 3;   // ORR
            else ok = 0;
            if (ok) fw = {f[0], f[0] && (ac < 2)};
        end
        pcs = (rw && rd == 4'hF) || kk == S_BRANCH;
        if (rst) begin irw = 0; npc = 0; end
        return {irw, npc, adr, asa, asb, rs, ac, op, op == 2'b01, op == 2'b10,
                fw, pcs, rw, mw};
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expand an instruction into its step list from its class.
    task automatic steps_of(input logic [1:0] op, input logic [5:0] f, output int q[$]);
        q = {S_FETCH, S_DECODE};
        case (op)
            2'b00: begin q.push_back(f[5] ? S_EXI : S_EXR); q.push_back(S_ALUWB); end
            2'b01: if (f[0]) begin q.push_back(S_MEMADR); q.push_back(S_MEMRD); q.push_back(S_MEMWB); end
                   else      begin q.push_back(S_MEMADR); q.push_back(S_MEMWR); end
            2'b10: q.push_back(S_BRANCH);
            default: ;
        endcase
    endtask

    // Entry: #1 after a rising edge with the DUT in FETCH. Exit: same.
    // rst_at >= 0 asserts reset in that step and abandons the instruction.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input int rst_at, input string tag);
        int q[$];
        steps_of(op, f, q);
        Op = op; Funct = f; Rd = rd;
        foreach (q[i]) begin
            bit r = (i == rst_at);
            reset = r;
            @(negedge clk);
            check($sformatf("%s step%0d", tag, i), observed(), model(q[i], op, f, rd, r));
            @(posedge clk); #1;
            if (r) begin reset = 1'b0; break; end
        end
        $display("instr %s op=%b funct=%b rd=%0d steps=%0d%s", tag, op, f, rd,
                 q.size(), (rst_at >= 0) ? " (reset mid-instruction)" : "");
    endtask

    initial begin
        logic [5:0] codes [4];
        codes[0] = 6'b001000; codes[1] = 6'b000100; codes[2] = 6'b000000; codes[3] = 6'b011000;
        reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_state", observed(), model(S_FETCH, 2'b00, 6'd0, 4'd0, 1));
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(2'b00, 6'b001001, 4'd3,  -1, "add_s");
        run_instr(2'b01, 6'b011001, 4'd15, -1, "ldr_pc");
        run_instr(2'b01, 6'b011000, 4'd2,  -1, "str");
        run_instr(2'b10, 6'b100000, 4'd0,  -1, "branch");
        run_instr(2'b00, 6'b111000, 4'd5,  -1, "orr_imm");
        run_instr(2'b00, 6'b100101, 4'd6,  -1, "sub_s");
        run_instr(2'b01, 6'b011001, 4'd4,   3, "ldr_rst");
        run_instr(2'b11, 6'b111111, 4'd15, -1, "illegal");
        run_instr(2'b00, 6'b010111, 4'd15, -1, "unk_alu");

        for (int n = 0; n < 150; n++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            logic [5:0] f  = 6'($urandom);
            logic [3:0] rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            int ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
            if ($urandom_range(0, 1) == 1)
                f = {f[5], codes[$urandom_range(0, 3)][4:1], f[0]};
            run_instr(op, f, rd, ra, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle control unit for the ARM-subset processor. It decodes the latched instruction fields and sequences each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath selects and the unconditional write strobes. It also drives the raw conditional-write requests (PCS, RegW, MemW, FlagW) that the downstream condition-check logic gates with CondEx.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Op  in  2  Instr[27:26] from the instruction register
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- IRWrite  out  1  load instruction register
- NextPC  out  1  unconditional PC write (fetch increment)
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut/Result
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- FlagW  out  2  flag-write request: [1] = N,Z; [0] = C,V
- PCS  out  1  PC-from-result request
- RegW  out  1  register-write request
- MemW  out  1  memory-write request

## Operation
- State register: 4 bits. States are FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR. Op=00 & Funct[5]=0→EXECUTER. Op=00 & Funct[5]=1→EXECUTEI. Op=10→BRANCH. Op=11 (illegal)→FETCH, no strobes.
  - MEMADR: Funct[0]=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH. BRANCH→FETCH.
- Moore outputs per state (unlisted outputs = 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode (ALUOp is internal):
  - ALUOp=0 → ALUControl=00, FlagW=00.
  - ALUOp=1 → decode Funct[4:1]: 0100→00, 0010→01, 0000→10, 1100→11. Any other value → ALUControl=00, FlagW=00.
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (ADD | SUB).
- PCS = (RegW & Rd==4'hF) | Branch.
- ImmSrc and RegSrc are combinational from Op in every state.

## Timing
- State updates on the rising edge of clk. Control outputs are combinational from the state and the registered instruction fields, with no added latency.
- Instruction cost:
  - Data-processing: 4 cycles (FETCH, DECODE, EXECUTEx, ALUWB).
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Illegal Op: 2 cycles.
- Op, Funct and Rd are sampled only in DECODE and later states; they are assumed stable from the cycle after IRWrite.
- Reset:
  - A reset edge forces state=FETCH.
  - While reset is high, IRWrite, NextPC, RegW, MemW, PCS and FlagW are forced to 0. Selects take their FETCH values.
  - The first IRWrite occurs in the first cycle after reset deasserts.
- Reset mid-instruction: at the next edge the FSM abandons the instruction and returns to FETCH. No write strobe is produced in the reset cycle.
- RegW, MemW, PCS and FlagW are requests only; gating by CondEx happens downstream. IRWrite and NextPC are never gated.

## Test plan
- **ADD with S=1, Rd=3:** Op=00, Funct=001001, Rd=3. Required sequence: FETCH, DECODE, EXECUTER (ALUControl=00, FlagW=11), ALUWB (RegW=1, PCS=0), then FETCH.
- **LDR into Rd=15:** Op=01, Funct=011001, Rd=15. Required: MEMRD has AdrSrc=1. MEMWB has ResultSrc=01, RegW=1, PCS=1. Total 5 cycles.
- **STR:** Op=01, Funct[0]=0. Required: MEMWR has MemW=1, AdrSrc=1, RegW=0, then FETCH. Total 4 cycles.
- **Branch:** Op=10. Required: BRANCH has PCS=1, ALUSrcB=01, ResultSrc=10. Returns to FETCH after 3 cycles.
- **Immediate ORR vs SUB:** Funct=111000 gives ALUControl=11, FlagW=00. SUB with S=1 (Funct=100101) gives ALUControl=01, FlagW=11.
- **Reset and illegal Op:**
  - Assert reset during MEMRD. Required: all strobes are 0 that cycle and the next state is FETCH.
  - Op=11 goes DECODE→FETCH with no RegW or MemW.
